// File: rtl/csa_add_arbiter.sv
// csa_add_arbiter: two valid/ready requesters share one carry-select adder;
// the sum lands in a single-entry result register with valid/ready backpressure.
// Optional build macro CSA_ARB_FIXED_PRIO_EN: fixed priority (requester 0 wins
// ties) instead of the default round-robin arbitration.

module csa_51bit #(
  parameter int unsigned WIDTH = 51,
  parameter int unsigned BLK   = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int unsigned NB = (WIDTH + BLK - 1) / BLK;

  logic [NB:0] c;

  assign c[0] = 1'b0;

  // Each block precomputes both carry-in cases; the ripple carry only drives muxes.
  for (genvar g = 0; g < NB; g++) begin : g_blk
    localparam int unsigned LO = g * BLK;
    localparam int unsigned BW = ((WIDTH - LO) < BLK) ? (WIDTH - LO) : BLK;
    logic [BW:0] s0;
    logic [BW:0] s1;
    assign s0 = {1'b0, a[LO +: BW]} + {1'b0, b[LO +: BW]};
    assign s1 = s0 + (BW+1)'(1);
    assign sum[LO +: BW] = c[g] ? s1[BW-1:0] : s0[BW-1:0];
    assign c[g+1]        = c[g] ? s1[BW]     : s0[BW];
  end

  assign cout = c[NB];
endmodule

module csa_add_arbiter #(
  parameter int unsigned WIDTH = 51
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [WIDTH-1:0] i_req0_add_term1,
  input  logic [WIDTH-1:0] i_req0_add_term2,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [WIDTH-1:0] i_req1_add_term1,
  input  logic [WIDTH-1:0] i_req1_add_term2,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WIDTH-1:0] o_res_sum,
  output logic             o_res_cout,
  output logic             o_res_id,
  output logic [15:0]      o_grant_cnt0,
  output logic [15:0]      o_grant_cnt1
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             prio;
  logic             any_valid;
  logic             grant_id;
  logic             can_accept;
  logic             xfer;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

`ifdef CSA_ARB_FIXED_PRIO_EN
  assign prio = 1'b0;
`else
  // Round-robin pointer: after a transfer the other requester gets the tie.
  always_ff @(posedge clk) begin
    if (!rst_n)    prio <= 1'b0;
    else if (xfer) prio <= ~grant_id;
  end
`endif

  // Arbitration, handshake, operand mux and next state.
  always_comb begin
    any_valid    = i_req0_valid | i_req1_valid;
    grant_id     = (i_req0_valid & i_req1_valid) ? prio : i_req1_valid;
    can_accept   = (state == EMPTY) | i_res_ready;
    o_req0_ready = rst_n & can_accept & any_valid & ~grant_id;
    o_req1_ready = rst_n & can_accept & any_valid &  grant_id;
    xfer         = o_req0_ready | o_req1_ready;
    add_a        = grant_id ? i_req1_add_term1 : i_req0_add_term1;
    add_b        = grant_id ? i_req1_add_term2 : i_req0_add_term2;
    state_nxt    = state;
    if (xfer)                                   state_nxt = FULL;
    else if ((state == FULL) && i_res_ready)    state_nxt = EMPTY;
  end

  csa_51bit #(.WIDTH(WIDTH)) u_adder (
    .a    (add_a),
    .b    (add_b),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Result register occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  assign o_res_valid = (state == FULL);

  // Result payload: loaded only on a transfer, otherwise held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_res_sum  <= '0;
      o_res_cout <= 1'b0;
      o_res_id   <= 1'b0;
    end else if (xfer) begin
      o_res_sum  <= add_sum;
      o_res_cout <= add_cout;
      o_res_id   <= grant_id;
    end
  end

  // Per-requester grant counters, free-running wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_grant_cnt0 <= '0;
      o_grant_cnt1 <= '0;
    end else begin
      if (o_req0_ready) o_grant_cnt0 <= o_grant_cnt0 + 16'd1;
      if (o_req1_ready) o_grant_cnt1 <= o_grant_cnt1 + 16'd1;
    end
  end
endmodule

// File: tb/tb_csa_add_arbiter.sv
// Self-checking bench for csa_add_arbiter: directed table, hand sequences for
// backpressure/reset/wrap, and randomized traffic against a behavioural model.
module tb_csa_add_arbiter;
  localparam int unsigned WIDTH = 51;
`ifdef CSA_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             i_req0_valid;
  logic             o_req0_ready;
  logic [WIDTH-1:0] i_req0_add_term1;
  logic [WIDTH-1:0] i_req0_add_term2;
  logic             i_req1_valid;
  logic             o_req1_ready;
  logic [WIDTH-1:0] i_req1_add_term1;
  logic [WIDTH-1:0] i_req1_add_term2;
  logic             o_res_valid;
  logic             i_res_ready;
  logic [WIDTH-1:0] o_res_sum;
  logic             o_res_cout;
  logic             o_res_id;
  logic [15:0]      o_grant_cnt0;
  logic [15:0]      o_grant_cnt1;

  csa_add_arbiter #(.WIDTH(WIDTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_req0_valid     (i_req0_valid),
    .o_req0_ready     (o_req0_ready),
    .i_req0_add_term1 (i_req0_add_term1),
    .i_req0_add_term2 (i_req0_add_term2),
    .i_req1_valid     (i_req1_valid),
    .o_req1_ready     (o_req1_ready),
    .i_req1_add_term1 (i_req1_add_term1),
    .i_req1_add_term2 (i_req1_add_term2),
    .o_res_valid      (o_res_valid),
    .i_res_ready      (i_res_ready),
    .o_res_sum        (o_res_sum),
    .o_res_cout       (o_res_cout),
    .o_res_id         (o_res_id),
    .o_grant_cnt0     (o_grant_cnt0),
    .o_grant_cnt1     (o_grant_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: occupancy flag, held result, counters, tie-break owner.
  bit               m_full = 1'b0;
  logic [WIDTH-1:0] m_sum  = '0;
  bit               m_cout = 1'b0;
  bit               m_id   = 1'b0;
  bit               m_prio = 1'b0;
  int unsigned      m_cnt0 = 0;
  int unsigned      m_cnt1 = 0;

  task automatic set_in(input bit v0, input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                        input bit v1, input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                        input bit rr);
    i_req0_valid = v0; i_req0_add_term1 = a0; i_req0_add_term2 = b0;
    i_req1_valid = v1; i_req1_add_term1 = a1; i_req1_add_term2 = b1;
    i_res_ready  = rr;
  endtask

  // Called just after a rising edge; checks readys at the falling edge and
  // registered outputs 1ns after the next rising edge.
  task automatic step(input bit quiet, output logic r0s, output logic r1s);
    int           w;
    bit           acc;
    bit           was_rst;
    logic [WIDTH:0] s;
    w = -1;
    if (i_req0_valid && i_req1_valid) w = FIXED ? 0 : int'(m_prio);
    else if (i_req0_valid)            w = 0;
    else if (i_req1_valid)            w = 1;
    acc = (rst_n === 1'b1) && (!m_full || (i_res_ready === 1'b1));
    @(negedge clk);
    r0s = o_req0_ready;
    r1s = o_req1_ready;
    if (!quiet) begin
      chk("req0_ready", 64'(r0s), 64'(acc && (w == 0)));
      chk("req1_ready", 64'(r1s), 64'(acc && (w == 1)));
    end
    @(posedge clk);
    was_rst = (rst_n !== 1'b1);
    if (was_rst) begin
      m_full = 0; m_sum = '0; m_cout = 0; m_id = 0; m_prio = 0; m_cnt0 = 0; m_cnt1 = 0;
    end else if (acc && (w >= 0)) begin
      if (w == 0) s = {1'b0, i_req0_add_term1} + {1'b0, i_req0_add_term2};
      else        s = {1'b0, i_req1_add_term1} + {1'b0, i_req1_add_term2};
      m_sum  = s[WIDTH-1:0];
      m_cout = s[WIDTH];
      m_id   = (w == 1);
      m_full = 1;
      if (w == 0) m_cnt0 = (m_cnt0 + 1) % 65536;
      else        m_cnt1 = (m_cnt1 + 1) % 65536;
      if (!FIXED) m_prio = (w == 0);
    end else if (m_full && (i_res_ready === 1'b1)) begin
      m_full = 0;
    end
    #1;
    if (!quiet) begin
      chk("res_valid", 64'(o_res_valid), 64'(m_full));
      chk("grant_cnt0", 64'(o_grant_cnt0), 64'(m_cnt0));
      chk("grant_cnt1", 64'(o_grant_cnt1), 64'(m_cnt1));
      if (m_full || was_rst) begin
        chk("res_sum", 64'(o_res_sum), 64'(m_sum));
        chk("res_cout", 64'(o_res_cout), 64'(m_cout));
        chk("res_id", 64'(o_res_id), 64'(m_id));
      end
    end
  endtask

  typedef struct {
    bit v0, v1, rr;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    bit er0, er1, ev;
    logic [WIDTH-1:0] esum;
    bit ecout, eid;
    logic [15:0] ec0, ec1;
  } vec_t;

  vec_t tbl[9];

  function automatic vec_t mk(input bit v0, input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                              input bit v1, input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                              input bit rr, input bit er0, input bit er1, input bit ev,
                              input logic [WIDTH-1:0] esum, input bit ecout, input bit eid,
                              input logic [15:0] ec0, input logic [15:0] ec1);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.b0 = b0; v.v1 = v1; v.a1 = a1; v.b1 = b1; v.rr = rr;
    v.er0 = er0; v.er1 = er1; v.ev = ev; v.esum = esum; v.ecout = ecout; v.eid = eid;
    v.ec0 = ec0; v.ec1 = ec1;
    return v;
  endfunction

  initial begin
    logic        r0s, r1s;
    logic [15:0] c0, c1;
    logic [63:0] t0, t1;
    bit          w1;

    // Directed table: single request, drain+refill, six-cycle contention, idle.
    tbl[0] = mk(1, 51'h7_FFFF_FFFF_FFFF, 51'd1, 0, '0, '0, 1, 1, 0, 1, 51'd0, 1, 0, 16'd1, 16'd0);
    tbl[1] = mk(0, '0, '0, 1, 51'd5, 51'd9, 1, 0, 1, 1, 51'd14, 0, 1, 16'd1, 16'd1);
    c0 = 16'd1; c1 = 16'd1;
    for (int k = 0; k < 6; k++) begin
      w1 = FIXED ? 1'b0 : ((k % 2) == 1);
      if (w1) c1 = c1 + 16'd1; else c0 = c0 + 16'd1;
      tbl[2+k] = mk(1, 51'd0, 51'd1, 1, 51'd1, 51'd1, 1, !w1, w1, 1,
                    w1 ? 51'd2 : 51'd1, 0, w1, c0, c1);
    end
    tbl[8] = mk(0, '0, '0, 0, '0, '0, 1, 0, 0, 0, '0, 0, 0, c0, c1);

    rst_n = 1'b0;
    set_in(1, 51'd3, 51'd4, 1, 51'd5, 51'd6, 1);
    @(posedge clk); #1;
    step(0, r0s, r1s);
    chk("reset_valid", 64'(o_res_valid), 64'd0);
    chk("reset_sum", 64'(o_res_sum), 64'd0);
    chk("reset_cnt0", 64'(o_grant_cnt0), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      set_in(tbl[i].v0, tbl[i].a0, tbl[i].b0, tbl[i].v1, tbl[i].a1, tbl[i].b1, tbl[i].rr);
      step(0, r0s, r1s);
      chk($sformatf("tbl%0d_ready0", i), 64'(r0s), 64'(tbl[i].er0));
      chk($sformatf("tbl%0d_ready1", i), 64'(r1s), 64'(tbl[i].er1));
      chk($sformatf("tbl%0d_valid", i), 64'(o_res_valid), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d_cnt0", i), 64'(o_grant_cnt0), 64'(tbl[i].ec0));
      chk($sformatf("tbl%0d_cnt1", i), 64'(o_grant_cnt1), 64'(tbl[i].ec1));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_sum", i), 64'(o_res_sum), 64'(tbl[i].esum));
        chk($sformatf("tbl%0d_cout", i), 64'(o_res_cout), 64'(tbl[i].ecout));
        chk($sformatf("tbl%0d_id", i), 64'(o_res_id), 64'(tbl[i].eid));
      end
    end

    // Backpressure: load 10+20 from requester 0, then stall four cycles.
    set_in(1, 51'd10, 51'd20, 1, 51'd100, 51'd200, 0);
    step(0, r0s, r1s);
    chk("bp_load_sum", 64'(o_res_sum), 64'd30);
    for (int k = 0; k < 4; k++) begin
      set_in(1, 51'(11 + k), 51'd20, 1, 51'(101 + k), 51'd200, 0);
      step(0, r0s, r1s);
      chk("bp_ready0", 64'(r0s), 64'd0);
      chk("bp_ready1", 64'(r1s), 64'd0);
      chk("bp_sum_hold", 64'(o_res_sum), 64'd30);
      chk("bp_id_hold", 64'(o_res_id), 64'd0);
    end
    set_in(1, 51'd1000, 51'd2000, 1, 51'd100, 51'd200, 1);
    step(0, r0s, r1s);
    chk("bp_release_ready1", 64'(r1s), FIXED ? 64'd0 : 64'd1);
    chk("bp_release_sum", 64'(o_res_sum), FIXED ? 64'd3000 : 64'd300);

    // Reset while full with both requesters asserting.
    rst_n = 1'b0;
    set_in(1, 51'd7, 51'd7, 1, 51'd8, 51'd8, 1);
    step(0, r0s, r1s);
    chk("mid_rst_ready0", 64'(r0s), 64'd0);
    chk("mid_rst_ready1", 64'(r1s), 64'd0);
    chk("mid_rst_valid", 64'(o_res_valid), 64'd0);
    chk("mid_rst_cnt1", 64'(o_grant_cnt1), 64'd0);
    rst_n = 1'b1;
    step(0, r0s, r1s);
    chk("post_rst_grant0", 64'(r0s), 64'd1);
    chk("post_rst_sum", 64'(o_res_sum), 64'd14);

    // Counter wrap: exactly 65536 grants to requester 0 from a clean reset.
    rst_n = 1'b0;
    step(0, r0s, r1s);
    rst_n = 1'b1;
    for (int k = 0; k < 65536; k++) begin
      set_in(1, 51'(k), 51'd1, 0, '0, '0, 1);
      step(1, r0s, r1s);
    end
    chk("wrap_cnt0", 64'(o_grant_cnt0), 64'd0);
    chk("wrap_cnt1", 64'(o_grant_cnt1), 64'd0);
    chk("wrap_valid", 64'(o_res_valid), 64'd1);
    chk("wrap_sum", 64'(o_res_sum), 64'd65536);
    chk("wrap_id", 64'(o_res_id), 64'd0);

    // Randomized traffic against the model, including all-ones operands and stray resets.
    for (int k = 0; k < 3000; k++) begin
      t0 = {$urandom(), $urandom()};
      t1 = {$urandom(), $urandom()};
      if ($urandom_range(9) == 0) t0 = '1;
      set_in($urandom_range(99) < 70, t0[WIDTH-1:0], t1[WIDTH-1:0],
             $urandom_range(99) < 70, t1[WIDTH-1:0], t0[WIDTH-1:0] ^ 51'h5555,
             $urandom_range(99) < 60);
      rst_n = ($urandom_range(199) != 0);
      step(0, r0s, r1s);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
